// File: rtl/noc_cfg_injector_if.sv
// Request and mesh-side signals of one noc_cfg_injector node.
// The slave modport is the injector; the master modport is the processor/mesh side.
interface noc_cfg_injector_if #(
  parameter int CFG_W = 11,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic [CFG_W-1:0] req_word;
  logic             req_ready;
  logic             processor_ready;
  logic [CFG_W-1:0] configure;
  logic             busy;
  logic             done_pulse;
  logic             timeout_pulse;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  req_valid, req_word, processor_ready,
    output req_ready, configure, busy, done_pulse, timeout_pulse, fifo_count
  );

  modport master (
    output req_valid, req_word, processor_ready,
    input  req_ready, configure, busy, done_pulse, timeout_pulse, fifo_count
  );
endinterface

// File: rtl/noc_cfg_injector.sv
// Per-node configure injector: FIFO of configure words, each held on the mesh
// configure input for HOLD_CYCLES, then tracked through accept/done on processor_ready.
module noc_cfg_injector #(
  parameter int CFG_W       = 11,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic                clock,
  input  logic                reset,
  noc_cfg_injector_if.slave   bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DRIVE     = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [CFG_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_state;
  logic [CFG_W-1:0]  r_cfg;
  logic [HOLD_W-1:0] r_hold;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_done;
  logic              r_tmo_pulse;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // Zero words complete the handshake but are never stored.
  assign w_push  = bus.req_valid && !w_full && (bus.req_word != '0);
  assign w_pop   = (r_state == S_IDLE) && !w_empty && bus.processor_ready;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.req_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pulses default low each cycle and are raised only on the completing edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cfg       <= '0;
      r_hold      <= '0;
      r_tmo       <= '0;
      r_done      <= 1'b0;
      r_tmo_pulse <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_tmo_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cfg   <= r_mem[r_rd_ptr];
            r_hold  <= HOLD_W'(1);
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_hold == HOLD_W'(HOLD_CYCLES)) begin
            r_cfg   <= '0;
            r_tmo   <= '0;
            r_state <= S_WAIT_ACK;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (!bus.processor_ready) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_tmo_pulse <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.processor_ready) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cfg   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = !w_full;
  assign bus.configure     = r_cfg;
  assign bus.busy          = (r_state != S_IDLE) || !w_empty;
  assign bus.done_pulse    = r_done;
  assign bus.timeout_pulse = r_tmo_pulse;
  assign bus.fifo_count    = r_count;
endmodule

// File: tb/tb_noc_cfg_injector.sv
// Self-checking bench for noc_cfg_injector: directed table, corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_noc_cfg_injector;
  localparam int CFG_W = 11;
  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int TMO   = 64;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  noc_cfg_injector_if #(.CFG_W(CFG_W), .DEPTH(DEPTH)) bus0 ();
  noc_cfg_injector_if #(.CFG_W(CFG_W), .DEPTH(DEPTH)) bus1 ();

  noc_cfg_injector #(.CFG_W(CFG_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  noc_cfg_injector #(.CFG_W(CFG_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: queue of words plus the edge number at which the current word was popped.
  int mq[$];
  int mPhase;
  int mPopEdge;
  int mCur;
  int mEdge = 0;
  bit mDone;
  bit mTmo;

  function automatic void modelEdge(input bit valid, input int word, input bit pr, input bit rst);
    bit acc;
    int k;
    mEdge++;
    if (rst) begin
      mq.delete();
      mPhase = 0;
      mCur   = 0;
      mDone  = 0;
      mTmo   = 0;
      return;
    end
    acc   = valid && (mq.size() < DEPTH);
    mDone = 0;
    mTmo  = 0;
    case (mPhase)
      0: if (mq.size() > 0 && pr) begin
        mCur     = mq.pop_front();
        mPopEdge = mEdge;
        mPhase   = 1;
      end
      1: begin
        k = mEdge - mPopEdge - HOLD;
        if (k > 0) begin
          if (!pr) mPhase = 2;
          else if (k == TMO) begin
            mTmo   = 1;
            mPhase = 0;
          end
        end
      end
      default: if (pr) begin
        mDone  = 1;
        mPhase = 0;
      end
    endcase
    if (acc && word != 0) mq.push_back(word);
  endfunction

  function automatic int modelCfg();
    return (mPhase == 1 && (mEdge - mPopEdge) < HOLD) ? mCur : 0;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [CFG_W-1:0] word, input bit pr, input bit rst);
    bus0.req_valid       = valid;
    bus0.req_word        = word;
    bus0.processor_ready = pr;
    reset                = rst;
    modelEdge(valid, int'(word), pr, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".configure"}, 32'(bus0.configure), modelCfg());
    checkValue({tag, ".fifo_count"}, 32'(bus0.fifo_count), mq.size());
    checkValue({tag, ".req_ready"}, 32'(bus0.req_ready), (mq.size() < DEPTH) ? 1 : 0);
    checkValue({tag, ".busy"}, 32'(bus0.busy), (mPhase != 0 || mq.size() != 0) ? 1 : 0);
    checkValue({tag, ".done_pulse"}, 32'(bus0.done_pulse), mDone);
    checkValue({tag, ".timeout_pulse"}, 32'(bus0.timeout_pulse), mTmo);
  endtask

  task automatic step(input bit valid, input logic [CFG_W-1:0] word, input bit pr, input bit rst, input string tag);
    applyStimulus(valid, word, pr, rst);
    checkOutput(tag);
  endtask

  typedef struct {
    bit               valid;
    logic [CFG_W-1:0] word;
    bit               pr;
    bit               rst;
    logic [CFG_W-1:0] cfg;
    int               cnt;
    bit               done;
    bit               busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int relAt, tmoAt, seen202;
    int drv0, drv1, dn0, dn1;
    bit pr0, pr1;
    logic [CFG_W-1:0] w;
    int prPct;

    bus0.req_valid = 0; bus0.req_word = '0; bus0.processor_ready = 1;
    bus1.req_valid = 0; bus1.req_word = '0; bus1.processor_ready = 1;
    reset = 1;

    // Reset then single request: hold 3 cycles, ack for 5 cycles of low ready, then done.
    vecs[0]  = '{1'b0, 11'h000, 1'b1, 1'b1, 11'h000, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 11'h205, 1'b1, 1'b0, 11'h000, 1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 11'h000, 1'b1, 1'b0, 11'h205, 0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 11'h000, 1'b1, 1'b0, 11'h205, 0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 11'h000, 1'b1, 1'b0, 11'h205, 0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 11'h000, 1'b1, 1'b0, 11'h000, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 11'h000, 1'b1, 1'b0, 11'h000, 0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].word, vecs[i].pr, vecs[i].rst);
      checkValue($sformatf("vec%0d.configure", i), 32'(bus0.configure), 32'(vecs[i].cfg));
      checkValue($sformatf("vec%0d.fifo_count", i), 32'(bus0.fifo_count), vecs[i].cnt);
      checkValue($sformatf("vec%0d.done_pulse", i), 32'(bus0.done_pulse), 32'(vecs[i].done));
      checkValue($sformatf("vec%0d.busy", i), 32'(bus0.busy), 32'(vecs[i].busy));
      checkValue($sformatf("vec%0d.timeout_pulse", i), 32'(bus0.timeout_pulse), 0);
      checkOutput($sformatf("vec%0d.model", i));
    end

    // FIFO full and in-order drain.
    step(0, '0, 0, 1, "full.rst");
    for (int i = 0; i < 5; i++) begin
      if (i == 4) checkValue("full.req_ready_before_fifth", 32'(bus0.req_ready), 0);
      step(1, CFG_W'(11'h201 + i), 0, 0, "full.push");
    end
    checkValue("full.fifo_count", 32'(bus0.fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, 0, "drain.pop");
      checkValue("drain.order", 32'(bus0.configure), 32'(11'h201 + i));
      step(0, '0, 1, 0, "drain.hold");
      step(0, '0, 1, 0, "drain.hold");
      step(0, '0, 1, 0, "drain.release");
      step(0, '0, 0, 0, "drain.ack");
      step(0, '0, 1, 0, "drain.done");
      checkValue("drain.done_pulse", 32'(bus0.done_pulse), 1);
    end

    // Timeout with processor_ready held high; next queued word still issues.
    step(0, '0, 1, 1, "tmo.rst");
    step(1, 11'h201, 1, 0, "tmo.push1");
    step(1, 11'h202, 1, 0, "tmo.push2");
    relAt = -1; tmoAt = -1; seen202 = 0;
    for (int i = 0; i < 150; i++) begin
      step(0, '0, 1, 0, "tmo.wait");
      if (relAt < 0 && bus0.configure == '0) relAt = i;
      if (tmoAt < 0 && bus0.timeout_pulse) tmoAt = i;
      if (bus0.configure == 11'h202) seen202 = 1;
    end
    checkValue("tmo.latency", tmoAt - relAt, TMO);
    checkValue("tmo.next_issued", seen202, 1);

    // Zero word is not stored; push and pop on the same edge keep the count.
    step(0, '0, 0, 1, "zero.rst");
    step(1, 11'h000, 0, 0, "zero.push");
    checkValue("zero.fifo_count", 32'(bus0.fifo_count), 0);
    step(1, 11'h201, 0, 0, "simul.push1");
    step(1, 11'h202, 0, 0, "simul.push2");
    step(1, 11'h203, 1, 0, "simul.pushpop");
    checkValue("simul.fifo_count", 32'(bus0.fifo_count), 2);
    checkValue("simul.configure", 32'(bus0.configure), 32'(11'h201));
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, "simul.tail");

    // Reset on the second hold cycle aborts the transfer and flushes the FIFO.
    step(0, '0, 1, 1, "rdrv.rst");
    step(1, 11'h205, 1, 0, "rdrv.push");
    step(1, 11'h206, 1, 0, "rdrv.pop");
    step(0, '0, 1, 0, "rdrv.hold2");
    checkValue("rdrv.configure_before", 32'(bus0.configure), 32'(11'h205));
    step(0, '0, 1, 1, "rdrv.abort");
    checkValue("rdrv.configure_after", 32'(bus0.configure), 0);
    checkValue("rdrv.fifo_count_after", 32'(bus0.fifo_count), 0);
    for (int i = 0; i < 8; i++) step(0, '0, (i % 3) != 1, 0, "rdrv.quiet");

    // Randomized traffic with bursts of steady-high ready to reach timeouts.
    step(0, '0, 1, 1, "rand.rst");
    prPct = 70;
    for (int i = 0; i < 1200; i++) begin
      if (i % 150 == 0) prPct = (prPct == 100) ? 70 : 100;
      w = ($urandom_range(0, 3) == 0) ? '0 : CFG_W'($urandom_range(1, 2047));
      step($urandom_range(0, 1) == 1, w, $urandom_range(1, 100) <= prPct,
           $urandom_range(0, 299) == 0, "rand");
    end

    // Two nodes pushed in the same cycle, with differently timed acknowledgement.
    step(0, '0, 1, 1, "dual.rst");
    drv0 = 0; drv1 = 0; dn0 = 0; dn1 = 0;
    for (int i = 0; i < 20; i++) begin
      pr0 = !(i >= 5 && i <= 7);
      pr1 = !(i >= 5 && i <= 10);
      bus1.req_valid       = (i == 0);
      bus1.req_word        = (i == 0) ? 11'h201 : 11'h000;
      bus1.processor_ready = pr1;
      step(i == 0, (i == 0) ? 11'h201 : 11'h000, pr0, 0, "dual.node0");
      if (bus0.configure == 11'h201) drv0++;
      if (bus1.configure == 11'h201) drv1++;
      if (bus0.done_pulse) dn0++;
      if (bus1.done_pulse) dn1++;
    end
    checkValue("dual.node0_drive", drv0, HOLD);
    checkValue("dual.node1_drive", drv1, HOLD);
    checkValue("dual.node0_done", dn0, 1);
    checkValue("dual.node1_done", dn1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
